// File: rtl/uart_rx_scheduler.sv
// uart_rx_scheduler: services a bank of uart_8bit receivers. Each lane watches
// its receiver's state for a completed byte, holds it until the round-robin
// arbiter forwards it on a valid/ready byte stream tagged with the channel
// number, and runs a silence watchdog that pulses the receiver reset.

// Per-channel capture, sticky flags, watchdog and receiver reset control.
module uart_rx_scheduler_lane #(
    parameter int              TO_W    = 16,
    parameter logic [TO_W-1:0] TIMEOUT = 16'd20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [2:0] estado,
    input  logic [7:0] rx_byte,
    input  logic       grant,
    input  logic       flag_clr,
    output logic       pend,
    output logic [7:0] hold,
    output logic       rx_rst,
    output logic       stale,
    output logic       ovf,
    output logic       err
);

    localparam logic [2:0]      ST_FIN  = 3'b100;
    localparam logic [2:0]      ST_ERR  = 3'b111;
    localparam logic [TO_W-1:0] WD_LAST = TIMEOUT - 1'b1;

    logic [2:0]      estado_q, estado_d;
    logic [7:0]      hold_q, hold_d;
    logic            pend_q, pend_d;
    logic            ovf_q, ovf_d;
    logic            err_q, err_d;
    logic            stale_q, stale_d;
    logic            rx_rst_q, rx_rst_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic            done, errev;

    // Events fire when the receiver leaves fin_recepcion (byte is stable by then)
    // or first enters error_lectura.
    always_comb begin
        done  = en && (estado_q == ST_FIN) && (estado != ST_FIN);
        errev = en && (estado_q != ST_ERR) && (estado == ST_ERR);
    end

    // Next-state for capture, flags and watchdog; set events override flag_clr.
    always_comb begin
        estado_d = estado;
        hold_d   = hold_q;
        pend_d   = pend_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        stale_d  = stale_q;
        wd_d     = wd_q;
        rx_rst_d = 1'b0;
        if (flag_clr) begin
            ovf_d = 1'b0;
            err_d = 1'b0;
        end
        if (!en) begin
            pend_d   = 1'b0;
            wd_d     = '0;
            stale_d  = 1'b0;
            rx_rst_d = 1'b1;
        end else begin
            if (grant) pend_d = 1'b0;
            if (done) begin
                // Newest byte wins; it only counts as an overflow if the old
                // one was not forwarded in this same cycle.
                hold_d  = rx_byte;
                pend_d  = 1'b1;
                stale_d = 1'b0;
                wd_d    = '0;
                if (pend_q && !grant) ovf_d = 1'b1;
            end else if (wd_q == WD_LAST) begin
                wd_d     = '0;
                stale_d  = 1'b1;
                rx_rst_d = 1'b1;
            end else begin
                wd_d = wd_q + 1'b1;
            end
            if (errev) err_d = 1'b1;
        end
    end

    // Lane state register; receivers are held in reset while the block is.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q <= 3'b000;
            hold_q   <= 8'h00;
            pend_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            stale_q  <= 1'b0;
            rx_rst_q <= 1'b1;
            wd_q     <= '0;
        end else begin
            estado_q <= estado_d;
            hold_q   <= hold_d;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            stale_q  <= stale_d;
            rx_rst_q <= rx_rst_d;
            wd_q     <= wd_d;
        end
    end

    assign pend   = pend_q;
    assign hold   = hold_q;
    assign rx_rst = rx_rst_q;
    assign stale  = stale_q;
    assign ovf    = ovf_q;
    assign err    = err_q;

endmodule

module uart_rx_scheduler #(
    parameter int              N_CH    = 4,
    parameter int              CH_W    = 2,
    parameter int              TO_W    = 16,
    parameter logic [TO_W-1:0] TIMEOUT = 16'd20000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   ch_en,
    input  logic [3*N_CH-1:0] rx_estado,
    input  logic [8*N_CH-1:0] rx_byte,
    output logic [N_CH-1:0]   rx_rst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic [N_CH-1:0]   stale,
    output logic [N_CH-1:0]   ovf,
    output logic [N_CH-1:0]   err,
    input  logic              flag_clr
);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} arb_state_t;

    arb_state_t            state_q, state_d;
    logic [7:0]            out_data_q, out_data_d;
    logic [CH_W-1:0]       out_ch_q, out_ch_d;
    logic [CH_W-1:0]       last_grant_q, last_grant_d;
    logic [N_CH-1:0]       pend;
    logic [N_CH-1:0][7:0]  hold;
    logic [N_CH-1:0]       grant;
    logic                  found;
    logic [CH_W-1:0]       win;
    logic                  load;

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        uart_rx_scheduler_lane #(
            .TO_W    (TO_W),
            .TIMEOUT (TIMEOUT)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .en       (ch_en[i]),
            .estado   (rx_estado[3*i +: 3]),
            .rx_byte  (rx_byte[8*i +: 8]),
            .grant    (grant[i]),
            .flag_clr (flag_clr),
            .pend     (pend[i]),
            .hold     (hold[i]),
            .rx_rst   (rx_rst[i]),
            .stale    (stale[i]),
            .ovf      (ovf[i]),
            .err      (err[i])
        );
    end

    // Round-robin search: first pending channel after the last one granted.
    always_comb begin
        int              idx;
        logic [CH_W-1:0] cand;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        cand  = '0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = int'(last_grant_q) + k;
            if (idx >= N_CH) idx = idx - N_CH;
            cand = CH_W'(idx);
            if (!found && pend[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Arbiter FSM: reload the output register whenever it is empty or drained.
    always_comb begin
        state_d      = state_q;
        out_data_d   = out_data_q;
        out_ch_d     = out_ch_q;
        last_grant_d = last_grant_q;
        grant        = '0;
        load         = (state_q == IDLE) || out_ready;
        if (load) begin
            if (found) begin
                state_d      = SEND;
                out_data_d   = hold[win];
                out_ch_d     = win;
                last_grant_d = win;
                grant[win]   = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // Arbiter and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            out_data_q   <= 8'h00;
            out_ch_q     <= '0;
            last_grant_q <= CH_W'(N_CH - 1);
        end else begin
            state_q      <= state_d;
            out_data_q   <= out_data_d;
            out_ch_q     <= out_ch_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_valid = (state_q == SEND);
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_uart_rx_scheduler.sv
// Scoreboard bench for uart_rx_scheduler: stimulus pushes expected beats,
// a negedge monitor pops and compares each accepted output beat.
module tb_uart_rx_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  ch_en = 4'h0;
    logic [11:0] rx_estado = 12'h000;
    logic [31:0] rx_byte = 32'h0;
    logic        out_ready = 1'b0;
    logic        flag_clr = 1'b0;
    logic [3:0]  rx_rst, stale, ovf, err;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] d;
    } exp_t;

    exp_t q[$];
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    uart_rx_scheduler #(
        .N_CH    (4),
        .CH_W    (2),
        .TO_W    (16),
        .TIMEOUT (16'd100)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ch_en     (ch_en),
        .rx_estado (rx_estado),
        .rx_byte   (rx_byte),
        .rx_rst    (rx_rst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .stale     (stale),
        .ovf       (ovf),
        .err       (err),
        .flag_clr  (flag_clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        compared++;
        if (act !== exp_v) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] c, input logic [7:0] d);
        exp_t e;
        e.ch = c;
        e.d  = d;
        q.push_back(e);
    endtask

    // Masked channels go 100 for one cycle, then 000; returns inside the done cycle.
    task automatic done_pulse(input logic [3:0] m, input logic [31:0] b);
        rx_byte = b;
        for (int c = 0; c < 4; c++) if (m[c]) rx_estado[3*c +: 3] = 3'b100;
        cyc(1);
        for (int c = 0; c < 4; c++) if (m[c]) rx_estado[3*c +: 3] = 3'b000;
    endtask

    // Monitor: every accepted beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_beat: got ch%0d data %h expected no beat", out_ch, out_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("beat_ch", 32'(out_ch), 32'(e.ch));
                chk("beat_data", 32'(out_data), 32'(e.d));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL sim_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        #2;
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_rx_rst", 32'(rx_rst), 32'hF);
        chk("rst_stale", 32'(stale), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_ch", 32'(out_ch), 32'd0);
        cyc(1);
        reset = 1'b1;
        out_ready = 1'b1;
        ch_en = 4'b0001;
        cyc(3);

        // Single sample: valid exactly two cycles after the done cycle, one beat
        push(2'd0, 8'hA5);
        done_pulse(4'b0001, 32'h000000A5);
        @(negedge clk) chk("lat_t", 32'(out_valid), 32'd0);
        @(negedge clk) chk("lat_t1", 32'(out_valid), 32'd0);
        @(negedge clk) chk("lat_t2", 32'(out_valid), 32'd1);
        @(negedge clk) chk("one_beat", 32'(out_valid), 32'd0);
        cyc(2);

        // Round-robin from last_grant=3: order 0,1,2,3 back to back
        ch_en = 4'hF;
        cyc(2);
        push(2'd3, 8'h3A);
        done_pulse(4'b1000, 32'h3A000000);
        cyc(4);
        push(2'd0, 8'h11); push(2'd1, 8'h22); push(2'd2, 8'h33); push(2'd3, 8'h44);
        done_pulse(4'b1111, 32'h44332211);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) @(negedge clk) chk("rr_burst_valid", 32'(out_valid), 32'd1);
        @(negedge clk) chk("rr_burst_end", 32'(out_valid), 32'd0);
        cyc(2);

        // Round-robin from last_grant=1: order 2,3,0,1
        push(2'd1, 8'h5A);
        done_pulse(4'b0010, 32'h00005A00);
        cyc(4);
        push(2'd2, 8'h33); push(2'd3, 8'h44); push(2'd0, 8'h11); push(2'd1, 8'h22);
        done_pulse(4'b1111, 32'h44332211);
        cyc(8);

        // Backpressure: ch0 stalls in the output, ch1 overwritten while pending
        out_ready = 1'b0;
        push(2'd0, 8'h0F);
        done_pulse(4'b0001, 32'h0000000F);
        cyc(3);
        @(negedge clk) chk("bp_stalled_valid", 32'(out_valid), 32'd1);
        cyc(1);
        done_pulse(4'b0010, 32'h00001000);
        cyc(2);
        done_pulse(4'b0010, 32'h00002000);
        cyc(2);
        @(negedge clk) chk("bp_ovf_set", 32'(ovf), 32'h2);
        push(2'd1, 8'h20);
        cyc(1);
        out_ready = 1'b1;
        cyc(4);
        @(negedge clk) chk("bp_drained", 32'(out_valid), 32'd0);
        cyc(1);
        flag_clr = 1'b1;
        cyc(1);
        flag_clr = 1'b0;
        @(negedge clk) chk("bp_ovf_clr", 32'(ovf), 32'd0);
        cyc(1);

        // Same-cycle grant and capture on ch2
        out_ready = 1'b0;
        push(2'd0, 8'h01);
        done_pulse(4'b0001, 32'h00000001);
        cyc(3);
        push(2'd2, 8'h55);
        done_pulse(4'b0100, 32'h00550000);
        cyc(3);
        push(2'd2, 8'h66);
        rx_byte = 32'h00660000;
        rx_estado[8:6] = 3'b100;
        cyc(1);
        rx_estado[8:6] = 3'b000;
        out_ready = 1'b1;
        cyc(5);
        @(negedge clk);
        chk("same_cycle_ovf", 32'(ovf), 32'd0);
        chk("same_cycle_drained", 32'(out_valid), 32'd0);
        cyc(1);

        // Watchdog: ch3 alone and silent, pulses at cycles 100 and 200
        ch_en = 4'b0000;
        cyc(2);
        ch_en = 4'b1000;
        @(negedge clk);
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            chk("wd_rx_rst3", 32'(rx_rst[3]), (k == 100 || k == 200) ? 32'd1 : 32'd0);
        end
        chk("wd_stale_set", 32'(stale), 32'h8);
        cyc(1);
        push(2'd3, 8'h7E);
        done_pulse(4'b1000, 32'h7E000000);
        cyc(1);
        @(negedge clk) chk("wd_stale_clr", 32'(stale), 32'd0);
        cyc(4);

        // Error, disable, asynchronous reset
        ch_en = 4'b1001;
        cyc(2);
        rx_estado[2:0] = 3'b111;
        cyc(1);
        @(negedge clk) chk("err_set", 32'(err), 32'h1);
        cyc(1);
        out_ready = 1'b0;
        done_pulse(4'b1000, 32'h33000000);
        cyc(3);
        done_pulse(4'b0001, 32'h000000C0);
        cyc(2);
        ch_en = 4'b1000;
        cyc(1);
        @(negedge clk) chk("dis_rx_rst0", 32'(rx_rst[0]), 32'd1);
        push(2'd3, 8'h33);
        cyc(1);
        out_ready = 1'b1;
        cyc(6);
        @(negedge clk) chk("dis_pend_dropped", 32'(out_valid), 32'd0);
        cyc(1);
        out_ready = 1'b0;
        done_pulse(4'b1000, 32'h3C000000);
        cyc(3);
        @(negedge clk) chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_rx_rst", 32'(rx_rst), 32'hF);
        cyc(2);
        reset = 1'b1;
        out_ready = 1'b1;
        cyc(6);
        @(negedge clk) chk("post_rst_no_data", 32'(out_valid), 32'd0);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
